// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter that serialises 32-bit word
// loads/stores from requesters A and B into four big-endian byte beats on a
// shared byte-wide RAM of 2^ADDR_W bytes.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN: when defined, word addresses
// with addr[1:0] != 0 are rejected with err instead of being executed.
//
// state | meaning
// IDLE  | waiting for a request, arbitration and request latch happen here
// XFER  | four byte beats to the RAM, beat counter 0..3
// DONE  | one-cycle done/err pulse to the granted port
module dmem_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  output logic              a_done,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic [31:0]       b_rdata,
  output logic              b_done,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_b;
  logic              gnt_b;
  logic              we_r;
  logic              err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rbuf;
  logic [1:0]        beat;

  logic              req_any;
  logic              win_b;
  logic              win_we;
  logic [31:0]       win_addr;
  logic [31:0]       win_wdata;
  logic              win_bad;
  logic [31:0]       ld_word;
  logic [7:0]        wbyte;

  // Round-robin pick: a tie goes to the port that was not granted last.
  always_comb begin
    req_any   = a_req | b_req;
    win_b     = b_req & (~a_req | ~last_b);
    win_we    = win_b ? b_we    : a_we;
    win_addr  = win_b ? b_addr  : a_addr;
    win_wdata = win_b ? b_wdata : a_wdata;
    win_bad   = |win_addr[31:ADDR_W];
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    win_bad   = win_bad | (|win_addr[1:0]);
`endif
  end

  // Current beat's store byte and the load word with this beat's lane filled in.
  always_comb begin
    wbyte   = 8'h00;
    ld_word = rbuf;
    case (beat)
      2'd0: begin wbyte = wdata_r[31:24]; ld_word[31:24] = mem_rdata; end
      2'd1: begin wbyte = wdata_r[23:16]; ld_word[23:16] = mem_rdata; end
      2'd2: begin wbyte = wdata_r[15:8];  ld_word[15:8]  = mem_rdata; end
      default: begin wbyte = wdata_r[7:0]; ld_word[7:0] = mem_rdata; end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; rejected requests bypass the RAM entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_any) state_nxt = win_bad ? DONE : XFER;
      XFER: if (beat == 2'd3) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, beat counter and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b  <= 1'b1;
      gnt_b   <= 1'b0;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rbuf    <= '0;
      beat    <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt_b   <= win_b;
            last_b  <= win_b;
            we_r    <= win_we;
            err_r   <= win_bad;
            addr_r  <= win_addr[ADDR_W-1:0];
            wdata_r <= win_wdata;
            beat    <= '0;
          end
        end
        XFER: begin
          beat <= beat + 2'd1;
          if (!we_r) begin
            rbuf <= ld_word;
            if (beat == 2'd3) begin
              if (gnt_b) b_rdata <= ld_word;
              else       a_rdata <= ld_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: RAM bus is quiet outside XFER, done/err only in DONE.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    a_done    = 1'b0;
    b_done    = 1'b0;
    a_err     = 1'b0;
    b_err     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      XFER: begin
        mem_addr  = addr_r + ADDR_W'(beat);
        mem_we    = we_r;
        mem_wdata = we_r ? wbyte : 8'h00;
      end
      DONE: begin
        a_done = ~gnt_b;
        b_done = gnt_b;
        a_err  = ~gnt_b & err_r;
        b_err  = gnt_b & err_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a word-level reference model predicts
// service order, completion cycle, err, load data and RAM byte writes.
module tb_dmem_arbiter;

  localparam int AW  = 5;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [31:0]   a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0]   a_rdata, b_rdata;
  logic          a_done, a_err, b_done, b_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          busy;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done), .b_err(b_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [MSZ];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < MSZ; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  typedef struct { bit port; bit err; logic [31:0] rd; int t; } exp_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  exp_t dq[$];
  wr_t  wq[$];

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [MSZ];
  logic [31:0] mrd [2];
  bit          last_m;
  logic [31:0] cur_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Word-level model of one granted transaction starting at sampling edge s.
  task automatic model_txn(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] data, input int s, output int t);
    bit bad;
    logic [31:0] rd;
    wr_t w;
    exp_t e;
    int ba;
    bad = (addr > 32'(MSZ - 1));
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (addr % 4 != 0) bad = 1'b1;
`endif
    rd = mrd[port];
    if (!bad) begin
      for (int k = 0; k < 4; k++) begin
        ba = (int'(addr) + k) % MSZ;
        if (we) begin
          w.a = AW'(ba);
          w.d = 8'(data >> (24 - 8 * k));
          wq.push_back(w);
          ref_mem[ba] = w.d;
        end else begin
          rd = {rd[23:0], ref_mem[ba]};
        end
      end
    end
    t = bad ? s : s + 4;
    mrd[port] = rd;
    e.port = port; e.err = bad; e.rd = rd; e.t = t;
    dq.push_back(e);
  endtask

  // na/nb: how many back-to-back services each port requests (req held across).
  task automatic do_round(input int na, input int nb,
                          input bit wa, input logic [31:0] aa, input logic [31:0] da,
                          input bit wb, input logic [31:0] ab, input logic [31:0] db);
    int pa, pb, s, t, ca, cb, budget;
    bit w;
    @(posedge clk); #1;
    a_req = (na > 0); a_we = wa; a_addr = aa; a_wdata = da;
    b_req = (nb > 0); b_we = wb; b_addr = ab; b_wdata = db;
    s = cyc + 1; pa = na; pb = nb;
    while (pa + pb > 0) begin
      if (pa > 0 && pb > 0) w = ~last_m;
      else                  w = (pb > 0);
      last_m = w;
      if (w) begin pb--; model_txn(1'b1, wb, ab, db, s, t); end
      else   begin pa--; model_txn(1'b0, wa, aa, da, s, t); end
      s = t + 2;
    end
    ca = 0; cb = 0; budget = 0;
    while ((ca < na || cb < nb) && budget < 12 * (na + nb) + 8) begin
      @(negedge clk);
      budget++;
      if (a_done === 1'b1) begin ca++; if (ca >= na) a_req = 1'b0; end
      if (b_done === 1'b1) begin cb++; if (cb >= nb) b_req = 1'b0; end
    end
    if (ca < na || cb < nb) begin
      checks++; errors++;
      $display("FAIL round_timeout actual_done=%0d/%0d required=%0d/%0d", ca, cb, na, nb);
      a_req = 1'b0; b_req = 1'b0;
    end
    repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    chk("done_queue_drained", 32'(dq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return $urandom | 32'h0000_0020;
    if (r < 4)  return 32'($urandom_range(0, 7) * 4);
    return 32'($urandom_range(0, MSZ - 1));
  endfunction

  // Monitor: pops the scoreboard on every done pulse and every RAM write beat.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (rst === 1'b1) begin cur_rd[0] = '0; cur_rd[1] = '0; end
    if (a_done === 1'b1 || b_done === 1'b1) begin
      if (a_done === 1'b1 && b_done === 1'b1) begin
        chk("both_done", 32'd1, 32'd0);
      end else if (dq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = dq.pop_front();
        chk("done_port", 32'(b_done), 32'(e.port));
        chk("done_err", e.port ? 32'(b_err) : 32'(a_err), 32'(e.err));
        chk("done_rdata", e.port ? b_rdata : a_rdata, e.rd);
        chk("done_cycle", 32'(cyc), 32'(e.t));
        cur_rd[e.port] = e.rd;
      end
    end
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        w = wq.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(w.a));
        chk("write_data", 32'(mem_wdata), 32'(w.d));
      end
    end
    if (busy === 1'b0)
      chk("idle_bus", {18'd0, mem_we, mem_wdata, mem_addr}, 32'd0);
    if (rst === 1'b0 && busy !== 1'bx) begin
      chk("a_rdata_hold", a_rdata, cur_rd[0]);
      chk("b_rdata_hold", b_rdata, cur_rd[1]);
    end
  end

  initial begin
    int budget;
    logic [31:0] x;
    logic [31:0] y;
    int na, nb;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = 8'(i * 37 + 5);
    mrd[0] = '0; mrd[1] = '0; last_m = 1'b1;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_flags", {26'd0, a_done, a_err, b_done, b_err, mem_we, busy}, 32'd0);
    chk("rst_mem", {19'd0, mem_wdata, mem_addr}, 32'd0);

    // Store then load of a known word, tie arbitration, wrap, out-of-range.
    do_round(1, 0, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    do_round(1, 0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0);
    do_round(2, 1, 1'b0, 32'h4, 32'h0, 1'b1, 32'h10, 32'hA5A5_5A5A);
    do_round(0, 1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1E, 32'h11223344);
    do_round(1, 0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0);
    do_round(0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1E, 32'h0);

    // Reset in the middle of a store: beats 0..2 land, nothing after.
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h8; a_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      wr_t w;
      w.a = AW'(8 + k);
      w.d = 8'(32'hCAFEF00D >> (24 - 8 * k));
      wq.push_back(w);
      ref_mem[8 + k] = w.d;
    end
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(mem_we === 1'b1 && mem_addr == AW'(9)) && budget < 20);
    chk("abort_reach_beat1", 32'(budget < 20), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; a_req = 1'b0;
    mrd[0] = '0; mrd[1] = '0; last_m = 1'b1;
    @(negedge clk);
    chk("abort_rdata", a_rdata | b_rdata, 32'd0);
    chk("abort_flags", {26'd0, a_done, a_err, b_done, b_err, mem_we, busy}, 32'd0);
    chk("abort_mem", {19'd0, mem_wdata, mem_addr}, 32'd0);
    repeat (8) @(posedge clk);
    chk("abort_writes_done", 32'(wq.size()), 32'd0);

    // Randomized traffic.
    for (int r = 0; r < 150; r++) begin
      na = $urandom_range(0, 2);
      nb = $urandom_range(0, 2);
      if (na + nb == 0) na = 1;
      x = rand_addr();
      y = rand_addr();
      do_round(na, nb, 1'($urandom), x, $urandom, 1'($urandom), y, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
